// File: rtl/core_host.sv
// Host sequencer: load N_IN operand bytes, pulse req, time the core until done, drain N_OUT result bytes.
// Latency: start->in_ready 1 cycle; REQ 1 cycle; done honoured from the 3rd RUN cycle. Optional watchdog: HOST_TIMEOUT_EN.
// Backpressure: in_valid low stalls LOAD, out_ready low stalls DRAIN with mem_addr/out_data held.
module core_host #(
    parameter int N_IN     = 8,
    parameter int IN_BASE  = 0,
    parameter int N_OUT    = 4,
    parameter int OUT_BASE = 32,
    parameter int CW       = 12,
    parameter int TIMEOUT  = 4095
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          req,
    input  logic          done,
    output logic          mem_wr_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_dat_out,
    input  logic [7:0]    mem_dat_in,
    output logic          busy,
    output logic          err,
    output logic [CW-1:0] cycles
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [7:0]    IN_BASE_B  = 8'(IN_BASE);
    localparam logic [7:0]    OUT_BASE_B = 8'(OUT_BASE);
    localparam logic [7:0]    LAST_IN    = 8'(N_IN - 1);
    localparam logic [7:0]    LAST_OUT   = 8'(N_OUT - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    // Counter values 1 and 2 are the masked RUN cycles where a stale done may linger
    localparam logic [CW-1:0] DONE_MASK  = CW'(2);

    logic [2:0]    state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cycles_q, cycles_d;

`ifdef HOST_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
`ifdef HOST_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    idx_d    = 8'd0;
                    cycles_d = '0;
`ifdef HOST_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == LAST_IN) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // REQ cycle counts as 0, so the first RUN cycle sees 1
                cnt_d   = CW'(1);
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (done && (cnt_q > DONE_MASK)) begin
                    cycles_d = cnt_q;
                    idx_d    = 8'd0;
                    state_d  = S_DRAIN;
                end
`ifdef HOST_TIMEOUT_EN
                else if (cnt_q >= TIMEOUT_CNT) begin
                    cycles_d = TIMEOUT_CNT;
                    err_d    = 1'b1;
                    state_d  = S_ERR;
                end
`endif
            end
            S_DRAIN: begin
                if (out_ready) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == LAST_OUT) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'd0;
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

`ifdef HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_addr    = 8'd0;
        mem_dat_out = 8'd0;
        case (state_q)
            S_LOAD: begin
                in_ready    = 1'b1;
                mem_wr_en   = in_valid;
                mem_addr    = IN_BASE_B + idx_q;
                mem_dat_out = in_data;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                mem_addr  = OUT_BASE_B + idx_q;
                out_data  = mem_dat_in;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign req    = (state_q == S_REQ);
    assign busy   = (state_q != S_IDLE);
    assign cycles = cycles_q;

endmodule

// File: tb/tb_core_host.sv
// Bench for core_host: behavioural data memory and core, write/readback scoreboards.
module tb_core_host;
    localparam int N_IN  = 8;
    localparam int IN_B  = 250;
    localparam int N_OUT = 4;
    localparam int OUT_B = 32;
    localparam int CW    = 12;
    localparam int TMO   = 100;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          req;
    logic          done;
    logic          mem_wr_en;
    logic [7:0]    mem_addr;
    logic [7:0]    mem_dat_out;
    logic [7:0]    mem_dat_in;
    logic          busy;
    logic          err;
    logic [CW-1:0] cycles;

    core_host #(
        .N_IN(N_IN), .IN_BASE(IN_B), .N_OUT(N_OUT), .OUT_BASE(OUT_B),
        .CW(CW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .req(req), .done(done),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat_out(mem_dat_out),
        .mem_dat_in(mem_dat_in), .busy(busy), .err(err), .cycles(cycles)
    );

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    int out_cnt = 0;

    logic [7:0]  mem [256];
    logic [7:0]  rslt [N_OUT];
    logic [15:0] wq [$];
    logic [7:0]  oq [$];
    logic [7:0]  off;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_dat = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: operand region is real storage, result region is what the core produced
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_dat_out;
    end

    always_comb begin
        off = mem_addr - 8'(OUT_B);
        mem_dat_in = mem[mem_addr];
        if (off < 8'(N_OUT)) mem_dat_in = rslt[int'(off)];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] val_of(input int id, input int i);
        return (id == 1) ? 8'(i + 1) : 8'((id * 37 + i * 11 + 5) & 255);
    endfunction

    always @(negedge clk) begin
        if (req) req_cnt++;
        if (mem_wr_en) begin
            if (wq.size() == 0) check("wr_extra", 32'(wq.size()), 32'd1);
            else check("wr", {16'd0, mem_addr, mem_dat_out}, {16'd0, wq.pop_front()});
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (oq.size() == 0) check("out_extra", 32'(oq.size()), 32'd1);
            else check("out", {24'd0, out_data}, {24'd0, oq.pop_front()});
        end
        if (prev_stall && out_valid) check("out_hold", {24'd0, out_data}, {24'd0, prev_dat});
        prev_stall = out_valid && !out_ready;
        prev_dat   = out_data;
    end

    task automatic load(input int id, input int nb, input bit bp);
        int i = 0;
        int guard = 0;
        while (i < nb && guard < 200) begin
            if (bp && (guard % 2 == 1)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = val_of(id, i);
                wq.push_back({8'(IN_B + i), val_of(id, i)});
                i++;
            end
            tick;
            guard++;
        end
        in_valid = 1'b0;
        check("load_bound", 32'(i), 32'(nb));
    endtask

    task automatic run(input int id, input int lat, input bit stale, input bit bp_in, input bit bp_out);
        int got = -1;
        int n = 0;
        int stall = 0;
        int guard = 0;
        bit hs;
        for (int j = 0; j < N_OUT; j++) begin
            rslt[j] = 8'($urandom_range(0, 255));
            oq.push_back(rslt[j]);
        end
        req_cnt = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("in_ready_lat", {31'd0, in_ready}, 32'd1);
        check("cycles_clr", 32'(cycles), 32'd0);
        load(id, N_IN, bp_in);
        check("req_hi", {31'd0, req}, 32'd1);
        check("req_addr", {24'd0, mem_addr}, 32'd0);
        done = stale;
        tick;
        for (int k = 1; k <= lat + 40; k++) begin
            done = (stale && k <= 2) || (k >= lat);
            tick;
            if (out_valid) begin
                got = k;
                break;
            end
        end
        done = 1'b0;
        check("done_cycle", 32'(got), 32'(lat));
        check("cycles", 32'(cycles), 32'(lat));
        while (n < N_OUT && guard < 100) begin
            out_ready = !(bp_out && n == 2 && stall < 3);
            if (!out_ready) stall++;
            hs = out_valid && out_ready;
            tick;
            if (hs) n++;
            guard++;
        end
        out_ready = 1'b1;
        check("drain_cnt", 32'(n), 32'(N_OUT));
        check("busy_end", {31'd0, busy}, 32'd0);
        check("oq_empty", 32'(oq.size()), 32'd0);
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("req_pulses", 32'(req_cnt), 32'd1);
        for (int i = 0; i < N_IN; i++)
            check("mem", {24'd0, mem[8'(IN_B + i)]}, {24'd0, val_of(id, i)});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        out_ready = 1'b1; done = 1'b0;
        for (int j = 0; j < N_OUT; j++) rslt[j] = 8'd0;
        repeat (3) tick;
        check("rst_ctl", {26'd0, req, in_ready, out_valid, mem_wr_en, busy, err}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_dat", {16'd0, mem_dat_out, out_data}, 32'd0);
        check("rst_cycles", 32'(cycles), 32'd0);
        reset = 1'b0;
        tick;

        run(1, 20, 1'b0, 1'b0, 1'b0);
        run(2, 12, 1'b0, 1'b1, 1'b1);
        run(3, 10, 1'b1, 1'b0, 1'b0);

        start = 1'b1;
        tick;
        start = 1'b0;
        load(9, 3, 1'b0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick;
        check("mrst_ctl", {26'd0, req, in_ready, out_valid, mem_wr_en, busy, err}, 32'd0);
        check("mrst_addr", {16'd0, mem_addr, mem_dat_out}, 32'd0);
        reset = 1'b0;
        tick;
        check("mrst_wq", 32'(wq.size()), 32'd0);
        run(4, 3, 1'b0, 1'b0, 1'b0);

`ifdef HOST_TIMEOUT_EN
        begin
            int k = 0;
            out_cnt = 0;
            start = 1'b1;
            tick;
            start = 1'b0;
            load(5, N_IN, 1'b0);
            done = 1'b0;
            while (busy && k < 400) begin
                tick;
                k++;
            end
            check("tmo_len", 32'(k), 32'd102);
            check("tmo_err", {31'd0, err}, 32'd1);
            check("tmo_busy", {31'd0, busy}, 32'd0);
            check("tmo_cycles", 32'(cycles), 32'(TMO));
            check("tmo_no_out", 32'(out_cnt), 32'd0);
            start = 1'b1;
            tick;
            start = 1'b0;
            check("tmo_err_clr", {31'd0, err}, 32'd0);
            reset = 1'b1;
            tick;
            reset = 1'b0;
            tick;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/core_host.md
# core_host

Host-side sequencer that drives the processor core's start/finish handshake (`req`/`done`) from the other end. It streams operand bytes into the core's data memory, pulses `req`, counts cycles until `done`, then reads the result bytes back out of data memory onto an output stream. It sits between the testbench or SoC host and the `top_level` core/data-memory pair, and owns the data-memory port whenever the core is not running.

## Interface
Parameters:
- `N_IN`, 8 — operand bytes preloaded per run (1..255)
- `IN_BASE`, 0 — data-memory address of first operand byte
- `N_OUT`, 4 — result bytes read back per run (1..255)
- `OUT_BASE`, 32 — data-memory address of first result byte
- `CW`, 12 — cycle-counter width
- `TIMEOUT`, 4095 — watchdog limit in run cycles (only with `HOST_TIMEOUT_EN`)

Ports:
- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — synchronous, active-high
- `start` input 1 — begin a run; sampled only in IDLE
- `in_valid` input 1 / `in_ready` output 1 / `in_data` input 8 — operand stream
- `out_valid` output 1 / `out_ready` input 1 / `out_data` output 8 — result stream
- `req` output 1 — one-cycle start pulse to core
- `done` input 1 — core finished (level)
- `mem_wr_en` output 1, `mem_addr` output 8, `mem_dat_out` output 8 — data-memory write/address port
- `mem_dat_in` input 8 — data-memory read data, combinational from `mem_addr`
- `busy` output 1 — high in every state except IDLE
- `err` output 1 — sticky watchdog error, cleared by next accepted `start`
- `cycles` output CW — cycles from `req` to `done` of last run, saturating at all-ones

## Operation
- States: IDLE, LOAD, REQ, RUN, DRAIN, ERR.
- IDLE: `start`=1 → LOAD; index cleared, `err` and `cycles` cleared.
- LOAD: `in_ready`=1; each `in_valid&in_ready` cycle writes `in_data` to `IN_BASE+idx` (`mem_wr_en`=1 that cycle only), idx++. After the N_IN-th write → REQ.
- REQ: `req`=1 for exactly one cycle; cycle counter cleared → RUN.
- RUN: counter increments every cycle (saturates). `done` is ignored for the first 2 RUN cycles (stale `done` from the previous program). Then `done`=1 → latch counter into `cycles`, idx cleared → DRAIN.
- DRAIN: `mem_addr`=`OUT_BASE+idx`, `out_data`=`mem_dat_in`, `out_valid`=1; on `out_valid&out_ready` idx++. After the N_OUT-th transfer → IDLE.
- ERR: `err`=1 → IDLE next cycle; `err` stays 1.
- Address arithmetic is 8-bit and wraps modulo 256 (e.g. base 250 + 8 bytes → 250..255, 0, 1).
- `mem_wr_en` is 0 outside LOAD; `mem_addr` is 0 in IDLE/REQ/RUN/ERR.
- `start` is ignored while `busy`.

## Timing
- Reset: state IDLE; `req`, `in_ready`, `out_valid`, `mem_wr_en`, `busy`, `err` = 0; `mem_addr`, `mem_dat_out`, `out_data`, `cycles` = 0.
- Reset asserted mid-run (any state) returns to IDLE the next edge and discards partial progress. It does not reset the core; a stale `done` is covered by the RUN mask.
- Minimum run: N_IN load cycles + 1 REQ + 3 RUN + N_OUT drain cycles. `start`-to-first-`in_ready` latency: 1 cycle.
- Back-pressure: `in_valid` low or `out_ready` low stalls LOAD/DRAIN indefinitely without side effects. `out_data` must be held stable while `out_valid&!out_ready`.
- `cycles` counts from the REQ cycle (=0) up to the cycle `done` is seen.

## Configuration
- `HOST_TIMEOUT_EN` defined: in RUN, counter reaching `TIMEOUT` without `done` → ERR. No readback is performed; `cycles`=`TIMEOUT`.
- Not defined: no watchdog. RUN waits forever, ERR is unreachable, `err` is tied 0.

## Test plan
- Normal run, N_IN=8, N_OUT=4: stream 0x01..0x08, core asserts `done` 20 cycles after `req` → memory 0..7 = 0x01..0x08, single `req` pulse, `cycles`=20, out stream = memory[32..35], `busy` falls after the 4th transfer.
- Back-pressure: `in_valid` toggling 50%, `out_ready` low 3 cycles mid-drain → no duplicate or missing writes, `out_data` held stable.
- Stale `done`: `done` already high at `req`, then low, then high at cycle 10 → `done` during the first 2 RUN cycles is ignored, `cycles`=10.
- Wrap: IN_BASE=250, N_IN=8 → writes to 250..255, 0, 1.
- Reset mid-LOAD after 3 bytes, then fresh `start` → state IDLE with all outputs zero, then a full 8-byte load starting at IN_BASE.
- With `HOST_TIMEOUT_EN`, TIMEOUT=100, `done` never asserted → `err`=1 after 100 RUN cycles, no `out_valid`, `busy`=0; next `start` clears `err`.
